mp_add_sequencer: RTL

//  Multi-precision add/subtract controller for the shared 16-bit hybrid carry-lookahead adder.

---
 rtl/mp_add_pkg.sv | 13 +
 rtl/mp_add_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/mp_add_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    localparam int ADDER_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/sub controller: streams WORDS 16-bit slices, LSW first, through an external adder.
// Latency: accept at edge t, out_valid from edge t+WORDS; one op per WORDS+2 cycles minimum.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no same-cycle turnaround.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_op,
    input  logic [WORDS*ADDER_W-1:0]   in_a,
    input  logic [WORDS*ADDER_W-1:0]   in_b,
    input  logic                       in_ci,
    output logic [ADDER_W-1:0]         adder_a,
    output logic [ADDER_W-1:0]         adder_b,
    output logic                       adder_ci,
    input  logic [ADDER_W-1:0]         adder_s,
    input  logic                       adder_co,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDS*ADDER_W-1:0]   out_sum,
    output logic                       out_co,
    output logic                       out_ovf
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    logic [1:0]                      state;
    logic [IDX_W-1:0]                idx;
    logic                            carry;
    logic [WORDS-1:0][ADDER_W-1:0]   a_reg;
    logic [WORDS-1:0][ADDER_W-1:0]   b_reg;
    logic [WORDS-1:0][ADDER_W-1:0]   sum_reg;
    logic                            is_run;
    logic                            last_slice;
    logic                            a_msb;
    logic                            b_eff_msb;

    assign is_run     = (state == ST_RUN);
    assign last_slice = (idx == IDX_LAST);
    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_sum    = sum_reg;

    assign a_msb     = a_reg[WORDS-1][ADDER_W-1];
    assign b_eff_msb = b_reg[WORDS-1][ADDER_W-1];

    assign adder_a  = is_run ? a_reg[idx] : '0;
    assign adder_b  = is_run ? b_reg[idx] : '0;
    assign adder_ci = is_run ? carry      : 1'b0;

    // The op is folded into b_reg (inverted) and the initial carry, so it needs no register of its own.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            out_co  <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= (in_op == OP_SUB) ? ~in_b : in_b;
                        carry <= (in_op == OP_SUB) ? ~in_ci : in_ci;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[idx] <= adder_s;
                    carry        <= adder_co;
                    if (last_slice) begin
                        idx     <= '0;
                        state   <= ST_DONE;
                        out_co  <= adder_co;
                        out_ovf <= (a_msb == b_eff_msb) && (adder_s[ADDER_W-1] != a_msb);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
